// File: rtl/gamepad_reader.sv
// gamepad_reader: NES-style serial pad scanner.
// Publishes a registered, conflict-free 8-button snapshot per poll.
module gamepad_reader #(
  parameter int CLK_DIV = 4
) (
  input  logic frame_clk,
  input  logic rst,
  input  logic poll,
  input  logic pad_data,
  output logic pad_latch,
  output logic pad_clk,
  output logic A,
  output logic B,
  output logic select,
  output logic start,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic valid,
  output logic busy
);

  localparam int DW = $clog2(2 * CLK_DIV);
  localparam logic [DW-1:0] LATCH_END = DW'(2 * CLK_DIV - 1);
  localparam logic [DW-1:0] PHASE_END = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    LOW,
    HIGH,
    DONE
  } state_t;

  state_t        state;
  logic [DW-1:0] div;
  logic [2:0]    idx;
  logic [7:0]    shift;
  logic          sync1;
  logic          sync2;
  logic [7:0]    cap;
  logic [7:0]    pub;

  // Shift contents including the bit being sampled now, then conflict-filtered.
  always_comb begin
    cap      = shift;
    cap[idx] = ~sync2;
    pub      = cap;
    if (cap[4] && cap[5]) pub[5:4] = 2'b00;
    if (cap[6] && cap[7]) pub[7:6] = 2'b00;
  end

  // Two-flop synchronizer; idles high so a floating line reads released.
  always_ff @(posedge frame_clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= pad_data;
      sync2 <= sync1;
    end
  end

  // Scan FSM; every output is registered alongside the state change.
  always_ff @(posedge frame_clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div       <= '0;
      idx       <= '0;
      shift     <= '0;
      pad_latch <= 1'b0;
      pad_clk   <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      {right, left, down, up, start, select, B, A} <= 8'h00;
    end else begin
      valid <= 1'b0;
      unique case (state)
        IDLE: begin
          div <= '0;
          if (poll) begin
            state     <= LATCH;
            pad_latch <= 1'b1;
            busy      <= 1'b1;
          end
        end
        LATCH: begin
          if (div == LATCH_END) begin
            div       <= '0;
            state     <= LOW;
            pad_latch <= 1'b0;
          end else begin
            div <= div + DW'(1);
          end
        end
        LOW: begin
          if (div == PHASE_END) begin
            div   <= '0;
            shift <= cap;
            if (idx == 3'd7) begin
              state <= DONE;
              valid <= 1'b1;
              {right, left, down, up, start, select, B, A} <= pub;
            end else begin
              state   <= HIGH;
              pad_clk <= 1'b1;
            end
          end else begin
            div <= div + DW'(1);
          end
        end
        HIGH: begin
          if (div == PHASE_END) begin
            div     <= '0;
            idx     <= idx + 3'd1;
            state   <= LOW;
            pad_clk <= 1'b0;
          end else begin
            div <= div + DW'(1);
          end
        end
        DONE: begin
          div   <= '0;
          idx   <= '0;
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          div       <= '0;
          idx       <= '0;
          pad_latch <= 1'b0;
          pad_clk   <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gamepad_reader.sv
// tb_gamepad_reader: directed scans against a shift-register pad model.
// Expected snapshots and timings are hand-computed for CLK_DIV=4.
module tb_gamepad_reader;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic poll = 1'b0;
  logic pad_data;
  logic pad_latch, pad_clk;
  logic A, B, select, start, up, down, left, right;
  logic valid, busy;

  logic [7:0] pmask = 8'h00;
  logic [3:0] pidx = 4'd0;
  logic [7:0] btns;

  int errs = 0;
  int checks = 0;

  gamepad_reader #(.CLK_DIV(4)) dut (
    .frame_clk(clk),
    .rst(rst),
    .poll(poll),
    .pad_data(pad_data),
    .pad_latch(pad_latch),
    .pad_clk(pad_clk),
    .A(A),
    .B(B),
    .select(select),
    .start(start),
    .up(up),
    .down(down),
    .left(left),
    .right(right),
    .valid(valid),
    .busy(busy)
  );

  always #5 clk = ~clk;

  assign btns = {right, left, down, up, start, select, B, A};

  // Pad model: latch reloads, each pad_clk rise advances one bit.
  always @(posedge pad_clk or posedge pad_latch) begin
    if (pad_latch) pidx <= 4'd0;
    else pidx <= pidx + 4'd1;
  end

  assign pad_data = pidx[3] ? 1'b1 : ~pmask[pidx[2:0]];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic scan(input string tag, input logic [7:0] m,
                      input logic [7:0] exp, input int poll2);
    int lat_n, lat_rise, hi_n, rises, ovl, vn, vat;
    int b1, b70;
    logic [7:0] vb;
    logic pl, pc;
    lat_n = 0; lat_rise = 0; hi_n = 0; rises = 0; ovl = 0;
    vn = 0; vat = -1; b1 = 0; b70 = 1; vb = 8'h00;
    pmask = m;
    pl = pad_latch;
    pc = pad_clk;
    @(negedge clk) poll = 1'b1;
    @(negedge clk) poll = 1'b0;
    for (int c = 1; c <= 160; c++) begin
      if (pad_latch) lat_n++;
      if (pad_latch && !pl) lat_rise++;
      if (pad_clk) hi_n++;
      if (pad_clk && !pc) rises++;
      if (pad_latch && pad_clk) ovl++;
      if (valid) begin
        vn++;
        vat = c;
        vb = btns;
      end
      if (c == 1) b1 = busy;
      if (c == 70) b70 = busy;
      pl = pad_latch;
      pc = pad_clk;
      @(negedge clk) poll = (c + 1 == poll2);
    end
    poll = 1'b0;
    check({tag, " latch_cycles"}, lat_n, 8);
    check({tag, " latch_rises"}, lat_rise, 1);
    check({tag, " clk_high_cycles"}, hi_n, 28);
    check({tag, " clk_rises"}, rises, 7);
    check({tag, " overlap"}, ovl, 0);
    check({tag, " valid_count"}, vn, 1);
    check({tag, " valid_cycle"}, vat, 69);
    check({tag, " snapshot"}, int'(vb), int'(exp));
    check({tag, " busy_start"}, b1, 1);
    check({tag, " busy_end"}, b70, 0);
    check({tag, " hold"}, int'(btns), int'(exp));
  endtask

  initial begin
    int vn;
    repeat (3) @(negedge clk);
    check("rst buttons", int'(btns), 0);
    check("rst busy", int'(busy), 0);
    check("rst latch", int'(pad_latch), 0);
    check("rst clk", int'(pad_clk), 0);
    check("rst valid", int'(valid), 0);
    rst = 1'b0;
    @(negedge clk);

    scan("basic", 8'b1000_0001, 8'b1000_0001, 0);
    scan("conflict", 8'b0111_0000, 8'b0100_0000, 0);
    scan("busy_poll", 8'b0000_1000, 8'b0000_1000, 20);

    pmask = 8'b0000_0100;
    @(negedge clk) poll = 1'b1;
    @(negedge clk) poll = 1'b0;
    repeat (29) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst buttons", int'(btns), 0);
    check("mid_rst busy", int'(busy), 0);
    check("mid_rst latch", int'(pad_latch), 0);
    check("mid_rst clk", int'(pad_clk), 0);
    check("mid_rst valid", int'(valid), 0);
    @(negedge clk) rst = 1'b0;
    vn = 0;
    repeat (9) begin
      @(negedge clk);
      if (valid) vn++;
    end
    check("mid_rst no_valid", vn, 0);
    scan("after_rst", 8'b0000_0010, 8'b0000_0010, 0);

    scan("disconnect", 8'b0000_0000, 8'b0000_0000, 0);
    scan("all_press", 8'b1111_1111, 8'b0000_1111, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/gamepad_reader.md
# gamepad_reader

Serial front end for the player controller inputs. On each poll request it drives the latch/clock protocol of an NES-style 8-button shift-register gamepad and samples the serial data line. It publishes one clean, registered, active-high snapshot of A, B, select, start, up, down, left and right, which feeds the player logic. Opposing directions are cancelled before publication, so downstream logic never sees a simultaneous up/down or left/right press.

## Interface
Parameters:
- CLK_DIV, default 4: frame_clk cycles per pad_clk half-period. Legal range is 3..255. Must be at least 3 to cover the 2-flop synchronizer delay.

Ports:
- frame_clk  input  1: single block clock; all state updates on its rising edge.
- rst  input  1: reset, asynchronous and active-high.
- poll  input  1: scan request, sampled only in IDLE.
- pad_data  input  1: serial data from the pad, active-low (0 = pressed). Passed through a 2-flop synchronizer before use.
- pad_latch  output  1: parallel-load strobe to the pad.
- pad_clk  output  1: shift clock to the pad; the pad shifts on its rising edge.
- A, B, select, start, up, down, left, right  output  1 each: registered button state, active-high.
- valid  output  1: one-cycle pulse when a new snapshot is published.
- busy  output  1: high in every state except IDLE.

## Operation
- Reset values: pad_latch=0, pad_clk=0, all eight button outputs=0, valid=0, busy=0, state=IDLE, bit index=0, divider=0, synchronizer flops=1.
- Reset is honoured in any state; a scan in progress is aborted with no partial update.
- States:
  - IDLE: if poll=1, go to LATCH and clear the divider. poll is ignored in all other states and is never queued.
  - LATCH: pad_latch=1, pad_clk=0, held for 2·CLK_DIV cycles, then go to LOW.
  - LOW: pad_latch=0, pad_clk=0, held for CLK_DIV cycles. On the last cycle, capture the inverted synchronized pad_data into shift bit[index]. If index=7, go to DONE; otherwise go to HIGH.
  - HIGH: pad_clk=1 for CLK_DIV cycles, then increment index and go to LOW.
  - DONE (1 cycle): load the button registers from the shift register, pulse valid=1, clear index, go to IDLE.
- Bit order: index 0..7 maps to A, B, select, start, up, down, left, right.
- Conflict rule, applied at DONE:
  - up&down both pressed: publish up=0, down=0.
  - left&right both pressed: publish left=0, right=0.
  - All other buttons are unaffected.
- Button outputs hold their last published value between scans. A disconnected pad (line pulled high) reads as all released.
- Bit index is 3 bits. The divider counter is wide enough for 2·CLK_DIV−1 and wraps to 0 on every state change.

## Timing
- Let edge k sample poll=1 in IDLE. Then:
  - pad_latch is high for cycles k+1..k+2·CLK_DIV.
  - This is followed by 8 LOW phases and 7 HIGH phases, each CLK_DIV cycles, alternating and starting with LOW.
  - Exactly 7 pad_clk rising edges occur per scan.
  - DONE occupies cycle k+17·CLK_DIV+1. Button outputs change and valid=1 in that same cycle.
- busy rises at edge k+1 and falls at the edge after DONE. A poll held continuously therefore starts a new scan every 17·CLK_DIV+2 cycles.
- Sampling happens at the end of each LOW phase, which gives CLK_DIV−2 cycles of settling after synchronizer delay.
- pad_latch and pad_clk are never high in the same cycle.
- Outputs are glitch-free: both are registered directly from state.

## Test plan
- Reset: assert rst mid-cycle with outputs non-zero. Required response: all outputs go to 0 immediately, without waiting for a clock edge, and busy=0.
- Basic scan, CLK_DIV=4, pad model returning the sequence 0,1,1,1,1,1,1,0 (A and right pressed), poll pulse at edge k. Required response:
  - pad_latch high exactly 8 cycles.
  - 7 pad_clk pulses, each 4 cycles high.
  - valid=1 only in cycle k+69, with A=1, right=1 and all other buttons 0.
- Conflict: pad reports up, down and left pressed. Required response: up=0, down=0, left=1, valid pulses once.
- Poll while busy: pulse poll at k and again at k+20. Required response: exactly one valid pulse (at k+69) and no second latch.
- Reset mid-scan: assert rst at k+30, release, then poll at k+40 with B pressed. Required response: no valid before the new scan; B=1 published at (k+40)+69.
- Disconnected pad: pad_data held at 1, then poll. Required response: valid pulses and all eight buttons read 0.
